// File: rtl/csi2tx_sync_update_ctrl.sv
// ---------------------------------------------------------------------------
// csi2tx_sync_update_ctrl
//
// Source-domain launch controller that feeds a mux-based clock-domain
// synchronizer. Each accepted update is presented on sync_data together with
// a one-cycle sync_enable pulse, and sync_data is then held stable for
// GUARD_CYCLES cycles so the far side can deliver and capture it. Writes that
// land inside that window are parked in a one-deep pending slot (latest
// value wins). Every parked value that gets overwritten before launch is
// counted in a saturating counter.
//
// Parameters:
//   DATA_WIDTH   - width of the update data
//   INIT_VALUE   - reset value of sync_data; keep equal to the synchronizer's
//   GUARD_CYCLES - hold time after each pulse, legal range 1..255
//
// Ports:
//   clk_src      in   source-domain clock (only clock in this block)
//   rsta_n       in   asynchronous active-low reset
//   wr_en        in   one-cycle write strobe from the register block
//   wr_data      in   write data, sampled when wr_en=1
//   coalesce_clr in   synchronous clear of coalesce_cnt
//   sync_data    out  registered data to the synchronizer's in_data
//   sync_enable  out  registered one-cycle launch pulse
//   busy         out  high while not idle
//   pending      out  high while the pending slot holds an unlaunched value
//   coalesce_cnt out  saturating count of overwritten pending values
// ---------------------------------------------------------------------------
module csi2tx_sync_update_ctrl #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
    parameter int                    GUARD_CYCLES = 8
) (
    input  logic                  clk_src,
    input  logic                  rsta_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  coalesce_clr,
    output logic [DATA_WIDTH-1:0] sync_data,
    output logic                  sync_enable,
    output logic                  busy,
    output logic                  pending,
    output logic [7:0]            coalesce_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        GUARD  = 2'd2
    } state_t;

    // The counter is loaded with GUARD_CYCLES-1 and runs down to 0, so the
    // GUARD state spans exactly GUARD_CYCLES cycles.
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            guard_cnt;
    logic [7:0]            guard_cnt_nxt;
    logic [DATA_WIDTH-1:0] sync_data_nxt;
    logic [DATA_WIDTH-1:0] pend_data;
    logic [DATA_WIDTH-1:0] pend_data_nxt;
    logic                  pending_nxt;
    logic                  coalesce_inc;

    // Next-state logic. A launch (entry into LAUNCH) is the only place where
    // sync_data is reloaded, which keeps it frozen for the whole guard window.
    // Writes that cannot launch immediately go to the pending slot; if the
    // slot was already full, the older value is dropped and counted.
    always_comb begin
        state_nxt     = state;
        guard_cnt_nxt = guard_cnt;
        sync_data_nxt = sync_data;
        pend_data_nxt = pend_data;
        pending_nxt   = pending;
        coalesce_inc  = 1'b0;

        case (state)
            IDLE: begin
                if (wr_en) begin
                    sync_data_nxt = wr_data;
                    state_nxt     = LAUNCH;
                end
            end

            LAUNCH: begin
                state_nxt     = GUARD;
                guard_cnt_nxt = GUARD_LOAD;
                if (wr_en) begin
                    pend_data_nxt = wr_data;
                    pending_nxt   = 1'b1;
                    coalesce_inc  = pending;
                end
            end

            GUARD: begin
                if (guard_cnt == 8'd0) begin
                    // A fresh write on the last guard cycle beats the parked
                    // value; the parked value is then the one discarded.
                    if (wr_en) begin
                        sync_data_nxt = wr_data;
                        state_nxt     = LAUNCH;
                        pending_nxt   = 1'b0;
                        coalesce_inc  = pending;
                    end else if (pending) begin
                        sync_data_nxt = pend_data;
                        state_nxt     = LAUNCH;
                        pending_nxt   = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    guard_cnt_nxt = guard_cnt - 8'd1;
                    if (wr_en) begin
                        pend_data_nxt = wr_data;
                        pending_nxt   = 1'b1;
                        coalesce_inc  = pending;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers. sync_enable and busy are registered
    // decodes of the next state so they line up exactly with LAUNCH / non-IDLE
    // without any combinational path to the synchronizer.
    always_ff @(posedge clk_src or negedge rsta_n) begin
        if (!rsta_n) begin
            state       <= IDLE;
            guard_cnt   <= 8'd0;
            sync_data   <= INIT_VALUE;
            pend_data   <= '0;
            pending     <= 1'b0;
            sync_enable <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            guard_cnt   <= guard_cnt_nxt;
            sync_data   <= sync_data_nxt;
            pend_data   <= pend_data_nxt;
            pending     <= pending_nxt;
            sync_enable <= (state_nxt == LAUNCH);
            busy        <= (state_nxt != IDLE);
        end
    end

    // Coalesce counter: clear has priority over a same-cycle increment, and
    // the count sticks at 255 rather than wrapping.
    always_ff @(posedge clk_src or negedge rsta_n) begin
        if (!rsta_n) begin
            coalesce_cnt <= 8'd0;
        end else if (coalesce_clr) begin
            coalesce_cnt <= 8'd0;
        end else if (coalesce_inc && (coalesce_cnt != 8'hFF)) begin
            coalesce_cnt <= coalesce_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_csi2tx_sync_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csi2tx_sync_update_ctrl
//
// Directed bench for csi2tx_sync_update_ctrl with GUARD_CYCLES=4 and a
// non-zero INIT_VALUE. Each scenario pushes the launches it expects
// (data + cycle) into a scoreboard queue; a monitor pops one entry for every
// sync_enable pulse and also flags any sync_data change outside a pulse.
// Cycle numbers are absolute; cycle c is the clock period that starts at the
// c-th rising edge.
// ---------------------------------------------------------------------------
module tb_csi2tx_sync_update_ctrl;

    localparam int          DW    = 32;
    localparam logic [31:0] INITV = 32'hDEAD_BEEF;
    localparam int          GC    = 4;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic          clk_src = 1'b0;
    logic          rsta_n  = 1'b0;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          coalesce_clr = 1'b0;
    logic [DW-1:0] sync_data;
    logic          sync_enable;
    logic          busy;
    logic          pending;
    logic [7:0]    coalesce_cnt;

    int   cyc     = 0;
    int   nChecks = 0;
    int   nFails  = 0;
    exp_t sbQ[$];

    csi2tx_sync_update_ctrl #(
        .DATA_WIDTH  (DW),
        .INIT_VALUE  (INITV),
        .GUARD_CYCLES(GC)
    ) dut (
        .clk_src     (clk_src),
        .rsta_n      (rsta_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .coalesce_clr(coalesce_clr),
        .sync_data   (sync_data),
        .sync_enable (sync_enable),
        .busy        (busy),
        .pending     (pending),
        .coalesce_cnt(coalesce_cnt)
    );

    // 10 ns clock and an absolute cycle counter used to time-stamp pulses.
    always #5 clk_src = ~clk_src;

    always @(posedge clk_src) cyc <= cyc + 1;

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge. Each pulse must match
    // the head of the queue in both data and cycle; sync_data may only move
    // in a cycle that carries a pulse.
    logic [31:0] prevData  = '0;
    logic        prevValid = 1'b0;

    always @(negedge clk_src) begin
        if (!rsta_n) begin
            prevData  = sync_data;
            prevValid = 1'b1;
        end else begin
            if (prevValid && (sync_data !== prevData))
                checkOutput("data_change_needs_pulse", {31'd0, sync_enable}, 32'd1);
            prevData  = sync_data;
            prevValid = 1'b1;
            if (sync_enable === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_pulse", sync_data, 32'hXXXX_XXXX);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("pulse_data", sync_data, e.data);
                    checkOutput("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepTo(input int c);
        while (cyc < c) begin
            @(posedge clk_src);
            #1;
        end
    endtask

    task automatic sampleAt(input int c);
        stepTo(c);
        @(negedge clk_src);
    endtask

    // Drive one cycle of stimulus at absolute cycle c, then release strobes.
    task automatic applyStimulus(input int c, input logic w, input logic [31:0] d,
                                 input logic clr);
        stepTo(c);
        wr_en        = w;
        wr_data      = d;
        coalesce_clr = clr;
        @(posedge clk_src);
        #1;
        wr_en        = 1'b0;
        coalesce_clr = 1'b0;
    endtask

    task automatic expectPulse(input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        sbQ.push_back(e);
    endtask

    task automatic checkDrained(input string name);
        checkOutput(name, sbQ.size(), 32'd0);
        sbQ.delete();
    endtask

    task automatic doReset();
        wr_en        = 1'b0;
        coalesce_clr = 1'b0;
        rsta_n       = 1'b0;
        repeat (2) @(posedge clk_src);
        #1;
        rsta_n = 1'b1;
        @(posedge clk_src);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_sync_data"}, sync_data, INITV);
        checkOutput({tag, "_sync_enable"}, {31'd0, sync_enable}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_pending"}, {31'd0, pending}, 32'd0);
        checkOutput({tag, "_coalesce_cnt"}, {24'd0, coalesce_cnt}, 32'd0);
    endtask

    initial begin
        int t0;
        int t1;

        // Single write: pulse only in t1, busy t1..t5.
        doReset();
        sampleAt(cyc);
        checkResetValues("reset");
        t0 = cyc + 1;
        expectPulse(32'hA5A5_0001, t0 + 1);
        applyStimulus(t0, 1'b1, 32'hA5A5_0001, 1'b0);
        for (int c = t0 + 1; c <= t0 + 7; c++) begin
            sampleAt(c);
            checkOutput("single_busy", {31'd0, busy},
                        {31'd0, (c >= t0 + 1) && (c <= t0 + 5)});
            checkOutput("single_enable", {31'd0, sync_enable}, {31'd0, c == t0 + 1});
            checkOutput("single_data", sync_data, 32'hA5A5_0001);
        end
        checkDrained("single_drained");

        // Spaced pair: second write parks, launches at t6.
        doReset();
        t0 = cyc + 1;
        expectPulse(32'h11, t0 + 1);
        expectPulse(32'h22, t0 + 6);
        applyStimulus(t0, 1'b1, 32'h11, 1'b0);
        applyStimulus(t0 + 2, 1'b1, 32'h22, 1'b0);
        for (int c = t0 + 3; c <= t0 + 5; c++) begin
            sampleAt(c);
            checkOutput("pair_pending", {31'd0, pending}, 32'd1);
        end
        sampleAt(t0 + 7);
        checkOutput("pair_pending_clear", {31'd0, pending}, 32'd0);
        checkOutput("pair_cnt", {24'd0, coalesce_cnt}, 32'd0);
        checkOutput("pair_data", sync_data, 32'h22);
        sampleAt(t0 + 12);
        checkOutput("pair_idle", {31'd0, busy}, 32'd0);
        checkDrained("pair_drained");

        // Coalesce: 0x22 is overwritten by 0x33 and never launched.
        doReset();
        t0 = cyc + 1;
        expectPulse(32'h11, t0 + 1);
        expectPulse(32'h33, t0 + 6);
        applyStimulus(t0, 1'b1, 32'h11, 1'b0);
        applyStimulus(t0 + 2, 1'b1, 32'h22, 1'b0);
        applyStimulus(t0 + 3, 1'b1, 32'h33, 1'b0);
        for (int c = t0 + 4; c <= t0 + 8; c++) begin
            sampleAt(c);
            checkOutput("coal_data", sync_data, (c < t0 + 6) ? 32'h11 : 32'h33);
        end
        checkOutput("coal_cnt", {24'd0, coalesce_cnt}, 32'd1);
        sampleAt(t0 + 12);
        checkDrained("coal_drained");

        // Final-cycle collision: fresh 0x44 beats parked 0x22.
        doReset();
        t0 = cyc + 1;
        expectPulse(32'h11, t0 + 1);
        expectPulse(32'h44, t0 + 6);
        applyStimulus(t0, 1'b1, 32'h11, 1'b0);
        applyStimulus(t0 + 2, 1'b1, 32'h22, 1'b0);
        applyStimulus(t0 + 5, 1'b1, 32'h44, 1'b0);
        sampleAt(t0 + 7);
        checkOutput("coll_pending", {31'd0, pending}, 32'd0);
        checkOutput("coll_cnt", {24'd0, coalesce_cnt}, 32'd1);
        checkOutput("coll_data", sync_data, 32'h44);
        sampleAt(t0 + 12);
        checkOutput("coll_idle", {31'd0, busy}, 32'd0);
        checkDrained("coll_drained");

        // Mid-guard reset: parked 0x22 is lost, no pulse after release.
        doReset();
        t0 = cyc + 1;
        expectPulse(32'h11, t0 + 1);
        applyStimulus(t0, 1'b1, 32'h11, 1'b0);
        applyStimulus(t0 + 2, 1'b1, 32'h22, 1'b0);
        stepTo(t0 + 3);
        rsta_n = 1'b0;
        #1;
        checkResetValues("midrst");
        repeat (2) @(posedge clk_src);
        #1;
        rsta_n = 1'b1;
        checkDrained("midrst_drained");
        t1 = cyc;
        for (int c = t1; c < t1 + 20; c++) begin
            sampleAt(c);
            checkOutput("midrst_no_pulse", {31'd0, sync_enable}, 32'd0);
            checkOutput("midrst_hold", sync_data, INITV);
        end

        // Saturation: write every cycle for 400 cycles. Launches happen at
        // k%5==0 and the last parked value goes out at t0+401.
        doReset();
        t0 = cyc + 1;
        for (int k = 0; k < 400; k++)
            if (k % 5 == 0) expectPulse(32'h1000_0000 + k, t0 + k + 1);
        expectPulse(32'h1000_0000 + 399, t0 + 401);
        for (int k = 0; k < 400; k++)
            applyStimulus(t0 + k, 1'b1, 32'h1000_0000 + k, 1'b0);
        sampleAt(t0 + 400);
        checkOutput("sat_cnt", {24'd0, coalesce_cnt}, 32'd255);
        sampleAt(t0 + 406);
        checkOutput("sat_cnt_hold", {24'd0, coalesce_cnt}, 32'd255);
        checkOutput("sat_idle", {31'd0, busy}, 32'd0);
        checkDrained("sat_drained");

        // Clear together with a coalescing write: clear wins.
        t1 = cyc + 1;
        expectPulse(32'hC0DE_0001, t1 + 1);
        expectPulse(32'hC0DE_0003, t1 + 6);
        applyStimulus(t1, 1'b1, 32'hC0DE_0001, 1'b0);
        applyStimulus(t1 + 1, 1'b1, 32'hC0DE_0002, 1'b0);
        applyStimulus(t1 + 2, 1'b1, 32'hC0DE_0003, 1'b1);
        sampleAt(t1 + 3);
        checkOutput("clr_cnt", {24'd0, coalesce_cnt}, 32'd0);
        checkOutput("clr_pending", {31'd0, pending}, 32'd1);
        sampleAt(t1 + 12);
        checkOutput("clr_cnt_after", {24'd0, coalesce_cnt}, 32'd0);
        checkDrained("clr_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
